// File: rtl/instr_sequencer_if.sv
// Decoder <-> sequencer bus for the picoMips instruction sequencer.
// slave: sequencer side, master: decoder side.
interface instr_sequencer_if #(
    parameter int unsigned ADDR_W = 5
);
    logic              i_wait_req;
    logic              i_branch_taken;
    logic [ADDR_W-1:0] i_branch_target;
    logic              i_halt_req;
    logic [ADDR_W-1:0] o_addr;
    logic [1:0]        o_stage;
    logic              o_hold;
    logic              o_halted;

    modport slave (
        input  i_wait_req,
        input  i_branch_taken,
        input  i_branch_target,
        input  i_halt_req,
        output o_addr,
        output o_stage,
        output o_hold,
        output o_halted
    );

    modport master (
        output i_wait_req,
        output i_branch_taken,
        output i_branch_target,
        output i_halt_req,
        input  o_addr,
        input  o_stage,
        input  o_hold,
        input  o_halted
    );
endinterface

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer for the picoMips core: drives the
// program-memory address and 2-bit execution stage, stalls on a switch
// press/release handshake, applies taken branches and halts at the
// instruction boundary (stage 3).
// Optional feature macro: HANDSHAKE_SYNC_EN adds a two-flop synchroniser
// on i_handshake; without it the raw input feeds the FSM directly.
module instr_sequencer #(
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned LAST_ADDR = 31
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_handshake,
    instr_sequencer_if.slave   bus
);
    localparam logic [1:0] STAGE_FETCH  = 2'd0;
    localparam logic [1:0] STAGE_DECODE = 2'd1;
    localparam logic [1:0] STAGE_EXEC   = 2'd2;
    localparam logic [1:0] STAGE_WB     = 2'd3;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_WAIT_HI = 2'd1,
        ST_WAIT_LO = 2'd2,
        ST_HALT    = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [1:0]        r_stage;
    logic [1:0]        w_stage_nxt;
    logic              r_hold;
    logic              r_halted;
    logic              w_hs;

`ifdef HANDSHAKE_SYNC_EN
    logic r_hs_meta;
    logic r_hs_sync;

    // Two-flop synchroniser for the asynchronous switch input
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hs_meta <= 1'b0;
            r_hs_sync <= 1'b0;
        end else begin
            r_hs_meta <= i_handshake;
            r_hs_sync <= r_hs_meta;
        end
    end

    assign w_hs = r_hs_sync;
`else
    assign w_hs = i_handshake;
`endif

    // State, address, stage and status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_RUN;
            r_addr   <= '0;
            r_stage  <= STAGE_FETCH;
            r_hold   <= 1'b0;
            r_halted <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_addr   <= w_addr_nxt;
            r_stage  <= w_stage_nxt;
            r_hold   <= (w_state_nxt != ST_RUN);
            r_halted <= (w_state_nxt == ST_HALT);
        end
    end

    // Next-state, next-address and next-stage decode
    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_stage_nxt = r_stage;
        case (r_state)
            ST_RUN: begin
                if (r_stage == STAGE_DECODE && bus.i_wait_req) begin
                    w_state_nxt = ST_WAIT_HI;
                end else if (r_stage == STAGE_WB) begin
                    if (bus.i_halt_req) begin
                        w_state_nxt = ST_HALT;
                    end else if (bus.i_branch_taken) begin
                        w_addr_nxt  = bus.i_branch_target;
                        w_stage_nxt = STAGE_FETCH;
                    end else begin
                        // Wrap only on an exact LAST_ADDR match; a branch past it
                        // runs on and wraps naturally at the top of the address space.
                        w_addr_nxt  = (r_addr == ADDR_W'(LAST_ADDR)) ? '0
                                                                      : r_addr + ADDR_W'(1);
                        w_stage_nxt = STAGE_FETCH;
                    end
                end else begin
                    w_stage_nxt = r_stage + 2'd1;
                end
            end
            ST_WAIT_HI: begin
                if (w_hs) begin
                    w_state_nxt = ST_WAIT_LO;
                end
            end
            ST_WAIT_LO: begin
                if (!w_hs) begin
                    w_state_nxt = ST_RUN;
                    w_stage_nxt = STAGE_EXEC;
                end
            end
            ST_HALT: begin
                w_state_nxt = ST_HALT;
            end
        endcase
    end

    assign bus.o_addr   = r_addr;
    assign bus.o_stage  = r_stage;
    assign bus.o_hold   = r_hold;
    assign bus.o_halted = r_halted;
endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: a table of per-cycle vectors for
// run/branch/halt behaviour plus hand-written wait, reset and wrap sequences.
module tb_instr_sequencer;
    localparam int unsigned AW = 5;
`ifdef HANDSHAKE_SYNC_EN
    localparam int HS_LAT = 2;
`else
    localparam int HS_LAT = 0;
`endif

    typedef struct {
        logic        w;
        logic        br;
        logic [4:0]  tgt;
        logic        halt;
        logic [4:0]  ea;
        logic [1:0]  es;
        logic        eh;
        logic        ehl;
    } vec_t;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic rst2 = 1'b1;
    logic hs   = 1'b0;
    logic hs2  = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    vec_t tbl [28];

    always #5 clk = ~clk;

    instr_sequencer_if #(.ADDR_W(AW)) bus ();
    instr_sequencer_if #(.ADDR_W(AW)) bus2 ();

    instr_sequencer #(.ADDR_W(AW), .LAST_ADDR(31)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_handshake (hs),
        .bus         (bus)
    );

    instr_sequencer #(.ADDR_W(AW), .LAST_ADDR(3)) dut_wrap (
        .clk         (clk),
        .rst         (rst2),
        .i_handshake (hs2),
        .bus         (bus2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_out(input string tag, input logic [4:0] ea, input logic [1:0] es,
                             input logic eh, input logic ehl);
        check({tag, ".addr"},   32'(bus.o_addr),   32'(ea));
        check({tag, ".stage"},  32'(bus.o_stage),  32'(es));
        check({tag, ".hold"},   32'(bus.o_hold),   32'(eh));
        check({tag, ".halted"}, 32'(bus.o_halted), 32'(ehl));
    endtask

    task automatic check_out2(input string tag, input logic [4:0] ea, input logic [1:0] es);
        check({tag, ".addr"},  32'(bus2.o_addr),  32'(ea));
        check({tag, ".stage"}, 32'(bus2.o_stage), 32'(es));
        check({tag, ".hold"},  32'(bus2.o_hold),  32'(1'b0));
    endtask

    task automatic set_req(input logic w, input logic br, input logic [4:0] tgt, input logic halt);
        bus.i_wait_req      = w;
        bus.i_branch_taken  = br;
        bus.i_branch_target = tgt;
        bus.i_halt_req      = halt;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference free-run step: stage counts 0..3, address advances on 3->0
    task automatic step(inout logic [4:0] a, inout logic [1:0] s, input logic [4:0] last);
        if (s == 2'd3) begin
            s = 2'd0;
            a = (a == last) ? 5'd0 : 5'(a + 5'd1);
        end else begin
            s = 2'(s + 2'd1);
        end
    endtask

    initial begin
        logic [4:0] ea;
        logic [1:0] es;
        int         cyc;

        //            w     br    tgt    halt  ea     es    hold  halted
        tbl[ 0] = '{1'b0, 1'b0, 5'd0,  1'b0, 5'd0,  2'd1, 1'b0, 1'b0};
        tbl[ 1] = '{1'b0, 1'b1, 5'd17, 1'b0, 5'd0,  2'd2, 1'b0, 1'b0};
        tbl[ 2] = '{1'b0, 1'b0, 5'd0,  1'b0, 5'd0,  2'd3, 1'b0, 1'b0};
        tbl[ 3] = '{1'b0, 1'b0, 5'd0,  1'b0, 5'd1,  2'd0, 1'b0, 1'b0};
        tbl[ 4] = '{1'b0, 1'b0, 5'd0,  1'b1, 5'd1,  2'd1, 1'b0, 1'b0};
        tbl[ 5] = '{1'b0, 1'b0, 5'd0,  1'b0, 5'd1,  2'd2, 1'b0, 1'b0};
        tbl[ 6] = '{1'b0, 1'b0, 5'd0,  1'b0, 5'd1,  2'd3, 1'b0, 1'b0};
        tbl[ 7] = '{1'b0, 1'b0, 5'd0,  1'b0, 5'd2,  2'd0, 1'b0, 1'b0};
        tbl[ 8] = '{1'b0, 1'b0, 5'd0,  1'b0, 5'd2,  2'd1, 1'b0, 1'b0};
        tbl[ 9] = '{1'b0, 1'b0, 5'd0,  1'b0, 5'd2,  2'd2, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 5'd0,  1'b0, 5'd2,  2'd3, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 5'd17, 1'b0, 5'd17, 2'd0, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 5'd0,  1'b0, 5'd17, 2'd1, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 5'd0,  1'b0, 5'd17, 2'd2, 1'b0, 1'b0};
        tbl[14] = '{1'b1, 1'b0, 5'd0,  1'b0, 5'd17, 2'd3, 1'b0, 1'b0};
        tbl[15] = '{1'b1, 1'b1, 5'd31, 1'b0, 5'd31, 2'd0, 1'b0, 1'b0};
        tbl[16] = '{1'b0, 1'b0, 5'd0,  1'b0, 5'd31, 2'd1, 1'b0, 1'b0};
        tbl[17] = '{1'b0, 1'b0, 5'd0,  1'b0, 5'd31, 2'd2, 1'b0, 1'b0};
        tbl[18] = '{1'b0, 1'b0, 5'd0,  1'b0, 5'd31, 2'd3, 1'b0, 1'b0};
        tbl[19] = '{1'b0, 1'b0, 5'd0,  1'b0, 5'd0,  2'd0, 1'b0, 1'b0};
        tbl[20] = '{1'b0, 1'b0, 5'd0,  1'b0, 5'd0,  2'd1, 1'b0, 1'b0};
        tbl[21] = '{1'b0, 1'b0, 5'd0,  1'b0, 5'd0,  2'd2, 1'b0, 1'b0};
        tbl[22] = '{1'b0, 1'b0, 5'd0,  1'b0, 5'd0,  2'd3, 1'b0, 1'b0};
        tbl[23] = '{1'b0, 1'b1, 5'd5,  1'b0, 5'd5,  2'd0, 1'b0, 1'b0};
        tbl[24] = '{1'b0, 1'b0, 5'd0,  1'b0, 5'd5,  2'd1, 1'b0, 1'b0};
        tbl[25] = '{1'b0, 1'b0, 5'd0,  1'b0, 5'd5,  2'd2, 1'b0, 1'b0};
        tbl[26] = '{1'b0, 1'b0, 5'd0,  1'b0, 5'd5,  2'd3, 1'b0, 1'b0};
        tbl[27] = '{1'b0, 1'b1, 5'd9,  1'b1, 5'd5,  2'd3, 1'b1, 1'b1};

        set_req(1'b0, 1'b0, 5'd0, 1'b0);
        bus2.i_wait_req      = 1'b0;
        bus2.i_branch_taken  = 1'b0;
        bus2.i_branch_target = 5'd0;
        bus2.i_halt_req      = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check_out("reset", 5'd0, 2'd0, 1'b0, 1'b0);
        rst = 1'b0;

        // Per-cycle vectors: stepping, ignored requests, branch, halt priority
        for (int i = 0; i < 28; i++) begin
            set_req(tbl[i].w, tbl[i].br, tbl[i].tgt, tbl[i].halt);
            tick();
            check_out($sformatf("vec%0d", i), tbl[i].ea, tbl[i].es, tbl[i].eh, tbl[i].ehl);
        end

        // HALT is absorbing regardless of decoder requests
        for (int i = 0; i < 20; i++) begin
            set_req(1'(i), 1'b1, 5'(i), 1'(i >> 1));
            tick();
            check_out("halt_hold", 5'd5, 2'd3, 1'b1, 1'b1);
        end
        set_req(1'b0, 1'b0, 5'd0, 1'b0);

        // Reset out of HALT
        rst = 1'b1;
        #1;
        check_out("rst_halt", 5'd0, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Free run, 40 cycles
        ea = 5'd0;
        es = 2'd0;
        for (int i = 0; i < 40; i++) begin
            tick();
            step(ea, es, 5'd31);
            check_out("free", ea, es, 1'b0, 1'b0);
        end

        // Handshake wait: enter at stage 1 (addr 10)
        tick();
        check_out("pre_wait", 5'd10, 2'd1, 1'b0, 1'b0);
        set_req(1'b1, 1'b0, 5'd0, 1'b0);
        tick();
        check_out("wait_enter", 5'd10, 2'd1, 1'b1, 1'b0);
        set_req(1'b0, 1'b0, 5'd0, 1'b0);
        repeat (3) begin
            tick();
            check_out("wait_hi", 5'd10, 2'd1, 1'b1, 1'b0);
        end
        hs = 1'b1;
        repeat (6) begin
            tick();
            check_out("wait_press", 5'd10, 2'd1, 1'b1, 1'b0);
        end
        hs = 1'b0;
        cyc = 0;
        while (bus.o_hold && cyc < 10) begin
            tick();
            cyc++;
        end
        check("release_latency", 32'(cyc), 32'(HS_LAT + 1));
        check_out("resume", 5'd10, 2'd2, 1'b0, 1'b0);
        tick();
        check_out("resume_s3", 5'd10, 2'd3, 1'b0, 1'b0);
        tick();
        check_out("resume_next", 5'd11, 2'd0, 1'b0, 1'b0);
        tick();
        check_out("pre_wait2", 5'd11, 2'd1, 1'b0, 1'b0);

        // Reset while in WAIT_LO
        set_req(1'b1, 1'b0, 5'd0, 1'b0);
        tick();
        check_out("wait2_enter", 5'd11, 2'd1, 1'b1, 1'b0);
        set_req(1'b0, 1'b0, 5'd0, 1'b0);
        hs = 1'b1;
        repeat (4) tick();
        check_out("wait2_lo", 5'd11, 2'd1, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_out("rst_wait", 5'd0, 2'd0, 1'b0, 1'b0);
        hs = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        ea = 5'd0;
        es = 2'd0;
        for (int i = 0; i < 8; i++) begin
            tick();
            step(ea, es, 5'd31);
            check_out("post_rst", ea, es, 1'b0, 1'b0);
        end

        // Wrap at LAST_ADDR=3
        check_out2("wrap_reset", 5'd0, 2'd0);
        rst2 = 1'b0;
        ea = 5'd0;
        es = 2'd0;
        for (int i = 0; i < 23; i++) begin
            tick();
            step(ea, es, 5'd3);
            check_out2("wrap", ea, es);
        end
        // Branch beyond LAST_ADDR runs on and wraps at 31
        bus2.i_branch_taken  = 1'b1;
        bus2.i_branch_target = 5'd30;
        tick();
        check_out2("wrap_branch", 5'd30, 2'd0);
        bus2.i_branch_taken  = 1'b0;
        bus2.i_branch_target = 5'd0;
        ea = 5'd30;
        es = 2'd0;
        for (int i = 0; i < 16; i++) begin
            tick();
            step(ea, es, 5'd3);
            check_out2("wrap_high", ea, es);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
